// File: rtl/overlay_tile_fetch_if.sv
// Memory-side bus of the overlay tile fetcher: tile-index RAM and font ROM read ports.
// Both memories return data one clk after the address is presented.
interface overlay_tile_fetch_if;
  logic [10:0] chram_addr;
  logic [7:0]  chram_q;
  logic [10:0] chrom_addr;
  logic [7:0]  chrom_q;

  modport master (output chram_addr, output chrom_addr, input chram_q, input chrom_q);
  modport slave  (input chram_addr, input chrom_addr, output chram_q, output chrom_q);
endinterface

// File: rtl/overlay_tile_fetch.sv
// Overlay character tile fetcher: reads tile index then font row one tile ahead of the
// raster and serialises the row into the coverage bit a_o with zero latency vs hcnt.
module overlay_tile_fetch #(
  parameter int         COLS    = 40,
  parameter int         ROWS    = 30,
  parameter logic [9:0] H_TOTAL = 10'd400,
  parameter logic [9:0] V_TOTAL = 10'd262
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce_pix_i,
  input  logic [9:0]           hcnt_i,
  input  logic [9:0]           vcnt_i,
  overlay_tile_fetch_if.master mem,
  output logic                 a_o
);
  localparam logic [7:0]  COLS_W = 8'(COLS);
  localparam logic [6:0]  ROWS_W = 7'(ROWS);
  localparam logic [10:0] COLS_A = 11'(COLS);
  localparam logic [10:0] ACT_W  = 11'(8 * COLS);
  localparam logic [10:0] ACT_H  = 11'(8 * ROWS);

  // ROMW waits out the font ROM read latency before PAT captures the row.
  typedef enum logic [2:0] {IDLE, IDX, FONT, ROMW, PAT} state_e;

  state_e      state_q;
  logic [10:0] chram_addr_q, chrom_addr_q;
  logic [2:0]  yl_q;
  logic [7:0]  pattern_q, shift_q, shift_d;
  logic        pending_q, pending_d;

  logic        line_start, tile_edge, trig, load;
  logic [7:0]  col_nxt;
  logic [6:0]  tgt_col, tgt_row;
  logic [9:0]  tgt_y;
  logic [10:0] idx_addr;

  always_comb begin
    line_start = (hcnt_i == H_TOTAL - 10'd8);
    col_nxt    = {1'b0, hcnt_i[9:3]} + 8'd1;
    tile_edge  = (hcnt_i[2:0] == 3'd0) && (col_nxt < COLS_W);
    tgt_col    = line_start ? 7'd0 : col_nxt[6:0];
    if (!line_start)                   tgt_y = vcnt_i;
    else if (vcnt_i == V_TOTAL - 10'd1) tgt_y = '0;
    else                               tgt_y = vcnt_i + 10'd1;
    tgt_row  = tgt_y[9:3];
    trig     = ce_pix_i && (line_start || tile_edge) && (tgt_row < ROWS_W);
    idx_addr = 11'(tgt_row) * COLS_A + 11'(tgt_col);
    load     = (hcnt_i[2:0] == 3'd7) || (hcnt_i == H_TOTAL - 10'd1);
  end

  // Blank tiles and rows past the last one load zeros because pending stays clear.
  always_comb begin
    shift_d   = shift_q;
    pending_d = pending_q;
    if (state_q == PAT) pending_d = 1'b1;
    if (ce_pix_i) begin
      if (load) begin
        shift_d   = pending_q ? pattern_q : 8'h00;
        pending_d = 1'b0;
      end else begin
        shift_d = {shift_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      chram_addr_q <= '0;
      chrom_addr_q <= '0;
      yl_q         <= '0;
      pattern_q    <= '0;
      shift_q      <= '0;
      pending_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      pending_q <= pending_d;
      case (state_q)
        IDLE: if (trig) begin
          chram_addr_q <= idx_addr;
          yl_q         <= tgt_y[2:0];
          state_q      <= IDX;
        end
        IDX:  state_q <= FONT;
        FONT: begin
          chrom_addr_q <= {mem.chram_q, yl_q};
          state_q      <= ROMW;
        end
        ROMW: state_q <= PAT;
        PAT: begin
          pattern_q <= mem.chrom_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.chram_addr = chram_addr_q;
  assign mem.chrom_addr = chrom_addr_q;
  assign a_o = shift_q[7] & ({1'b0, hcnt_i} < ACT_W) & ({1'b0, vcnt_i} < ACT_H);

  // A new tile trigger must never land on an in-flight fetch.
  a_no_busy_trig: assert property (@(posedge clk) disable iff (reset) trig |-> state_q == IDLE);
endmodule
